// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin, packet-locked write arbiter in front of a FIFO write port
module fifo_write_arbiter #(
    parameter int NumReq  = 4,
    parameter int Width   = 9,
    parameter int IdWidth = 2
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic [NumReq-1:0]         Req,
    input  logic [NumReq*Width-1:0]   ReqDin,
    input  logic [NumReq-1:0]         ReqLast,
    output logic [NumReq-1:0]         Ack,
    output logic                      FifoWrite,
    output logic [Width-1:0]          FifoDin,
    input  logic                      FifoFull,
    input  logic                      FifoProgFull,
    output logic                      Busy,
    output logic [IdWidth-1:0]        GrantId
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IdWidth-1:0] last_q;
    logic [IdWidth-1:0] last_next;
    logic [IdWidth-1:0] grant_q;
    logic [IdWidth-1:0] grant_next;
    logic [IdWidth-1:0] pick;
    logic [IdWidth-1:0] cand;
    logic               pick_valid;
    logic [Width-1:0]   din_arr [NumReq];

    genvar gi;
    generate
        for (gi = 0; gi < NumReq; gi++) begin : g_slice
            assign din_arr[gi] = ReqDin[gi*Width +: Width];
        end
    endgenerate

    // Round-robin search: scan farthest-first so the nearest requester after Last wins.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        cand       = '0;
        for (int k = NumReq; k >= 1; k--) begin
            cand = IdWidth'((int'(last_q) + k) % NumReq);
            if (Req[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    // Write-port decode: only the owner can be acked, and only while the FIFO has room.
    always_comb begin
        Ack     = '0;
        FifoDin = '0;
        if (state == BURST) begin
            Ack[grant_q] = Req[grant_q] & ~FifoFull;
            FifoDin      = din_arr[grant_q];
        end
    end

    assign FifoWrite = |Ack;

    // Next-state: arbitrate in IDLE below prog-full; leave BURST only once the last word is written.
    always_comb begin
        state_next = state;
        last_next  = last_q;
        grant_next = grant_q;
        case (state)
            IDLE: begin
                if (pick_valid && !FifoProgFull) begin
                    state_next = BURST;
                    last_next  = pick;
                    grant_next = pick;
                end
            end
            BURST: begin
                if (Ack[grant_q] && ReqLast[grant_q]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, pointer and grant registers; Last resets to the top index so requester 0 is searched first.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            last_q  <= IdWidth'(NumReq - 1);
            grant_q <= '0;
        end else begin
            state   <= state_next;
            last_q  <= last_next;
            grant_q <= grant_next;
        end
    end

    assign Busy    = (state == BURST);
    assign GrantId = grant_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - randomized and directed bench with behavioural model for fifo_write_arbiter
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int W  = 9;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req;
    logic [N*W-1:0]  req_din;
    logic [N-1:0]    req_last;
    logic [N-1:0]    ack;
    logic            fifo_write;
    logic [W-1:0]    fifo_din;
    logic            fifo_full;
    logic            fifo_prog_full;
    logic            busy;
    logic [IW-1:0]   grant_id;

    fifo_write_arbiter #(.NumReq(N), .Width(W), .IdWidth(IW)) dut (
        .Clk          (clk),
        .Reset_n      (reset_n),
        .Req          (req),
        .ReqDin       (req_din),
        .ReqLast      (req_last),
        .Ack          (ack),
        .FifoWrite    (fifo_write),
        .FifoDin      (fifo_din),
        .FifoFull     (fifo_full),
        .FifoProgFull (fifo_prog_full),
        .Busy         (busy),
        .GrantId      (grant_id)
    );

    always #5 clk = ~clk;

    // Per-requester word queues: bits[8:0] data, bit 9 last, bits[31:10] idle cycles before the word.
    int           wq [N][$];
    logic [N-1:0] pop_pend;

    // Behavioural model: who owns the port, and the last index granted.
    bit m_busy;
    int m_owner;
    int m_last;
    int cycle;

    int grant_log[$];
    int fifo_log[$];
    int fifo_cyc[$];
    int exp_q[$];

    int n_total;
    int n_pass;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cycle);
    endtask

    task automatic chk_seq(input string name, input int got[$], input int want[$]);
        chk({name, "_len"}, 64'(got.size()), 64'(want.size()));
        for (int i = 0; i < got.size() && i < want.size(); i++)
            chk(name, 64'(got[i]), 64'(want[i]));
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_ack"},   64'(ack), 64'(0));
        chk({name, "_write"}, 64'(fifo_write), 64'(0));
        chk({name, "_din"},   64'(fifo_din), 64'(0));
        chk({name, "_busy"},  64'(busy), 64'(0));
        chk({name, "_gid"},   64'(grant_id), 64'(0));
    endtask

    function automatic int mkw(input int gap, input int lst, input int data);
        return (gap << 10) | (lst << 9) | (data & 511);
    endfunction

    task automatic push_word(input int r, input int gap, input int lst, input int data);
        wq[r].push_back(mkw(gap, lst, data));
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_last  = N - 1;
    endtask

    task automatic clear_logs();
        grant_log.delete();
        fifo_log.delete();
        fifo_cyc.delete();
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (wq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    // Requester side: retire acked words, then present the next word once its gap has elapsed.
    task automatic drive();
        for (int i = 0; i < N; i++)
            if (pop_pend[i] && wq[i].size() > 0) void'(wq[i].pop_front());
        pop_pend = '0;
        for (int i = 0; i < N; i++) begin
            if (wq[i].size() > 0 && (wq[i][0] >>> 10) > 0) begin
                req[i] = 1'b0;
                wq[i][0] = wq[i][0] - 1024;
                req_din[i*W +: W] = W'($urandom);
                req_last[i] = 1'($urandom);
            end else if (wq[i].size() > 0) begin
                req[i] = 1'b1;
                req_din[i*W +: W] = W'(wq[i][0] & 511);
                req_last[i] = ((wq[i][0] >>> 9) & 1) != 0;
            end else begin
                req[i] = 1'b0;
                req_din[i*W +: W] = W'($urandom);
                req_last[i] = 1'($urandom);
            end
        end
    endtask

    // Compare DUT outputs with the model, then advance the model across the coming edge.
    task automatic check_cycle();
        logic [N-1:0] e_ack;
        logic [W-1:0] e_din;
        int           pick;
        e_ack = '0;
        e_din = '0;
        if (m_busy) begin
            e_ack[m_owner] = req[m_owner] & ~fifo_full;
            e_din = req_din[m_owner*W +: W];
        end
        chk("ack",   64'(ack), 64'(e_ack));
        chk("write", 64'(fifo_write), 64'(|e_ack));
        chk("din",   64'(fifo_din), 64'(e_din));
        chk("busy",  64'(busy), 64'(m_busy));
        chk("gid",   64'(grant_id), 64'(m_owner));
        if (fifo_write) begin
            fifo_log.push_back(int'(fifo_din));
            fifo_cyc.push_back(cycle);
        end
        pop_pend = e_ack;
        if (m_busy) begin
            if (e_ack != '0 && req_last[m_owner]) m_busy = 1'b0;
        end else if (req != '0 && !fifo_prog_full) begin
            pick = -1;
            for (int k = 1; k <= N; k++)
                if (pick < 0 && req[(m_last + k) % N]) pick = (m_last + k) % N;
            m_busy  = 1'b1;
            m_owner = pick;
            m_last  = pick;
            grant_log.push_back(pick);
        end
        cycle++;
    endtask

    task automatic step();
        drive();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int g;
        g = 0;
        while ((pending() || m_busy) && g < 3000) begin
            step();
            g++;
        end
        chk({name, "_drained"}, 64'(g < 3000), 64'(1));
    endtask

    int start_cyc;
    int words_pushed;
    int nlog;
    int g;

    initial begin
        n_total = 0;
        n_pass  = 0;
        cycle   = 0;
        pop_pend = '0;
        reset_n = 1'b0;
        req = 4'hF;
        req_din = '1;
        req_last = '1;
        fifo_full = 1'b0;
        fifo_prog_full = 1'b0;
        model_reset();

        // Reset held with requests pending: outputs must sit at reset values.
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        req = '0;
        reset_n = 1'b1;

        // Round-robin: all four requesters, three 2-word packets each.
        clear_logs();
        for (int p = 0; p < 3; p++)
            for (int r = 0; r < N; r++) begin
                push_word(r, 0, 0, 16 * r + 2 * p);
                push_word(r, 0, 1, 16 * r + 2 * p + 1);
            end
        start_cyc = cycle;
        drain("rr");
        exp_q = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
        chk_seq("rr_grants", grant_log, exp_q);
        chk("rr_first_latency", 64'(fifo_cyc[0] - start_cyc), 64'(1));
        chk("rr_span", 64'(fifo_cyc[23] - fifo_cyc[0]), 64'(34));

        // Single requester 2, three-word packet.
        clear_logs();
        push_word(2, 0, 0, 'h101);
        push_word(2, 0, 0, 'h002);
        push_word(2, 0, 1, 'h1FF);
        drain("single");
        exp_q = '{2};
        chk_seq("single_grants", grant_log, exp_q);
        exp_q = '{'h101, 'h002, 'h1FF};
        chk_seq("single_data", fifo_log, exp_q);
        chk("single_consecutive", 64'(fifo_cyc[2] - fifo_cyc[0]), 64'(2));

        // No interleave: requester 1 stalls 5 cycles mid-packet while 3 waits.
        clear_logs();
        push_word(1, 0, 0, 'h0A1);
        push_word(1, 5, 0, 'h0A2);
        push_word(1, 0, 1, 'h0A3);
        push_word(3, 2, 0, 'h0C1);
        push_word(3, 0, 1, 'h0C2);
        drain("nointlv");
        exp_q = '{1, 3};
        chk_seq("nointlv_grants", grant_log, exp_q);
        exp_q = '{'h0A1, 'h0A2, 'h0A3, 'h0C1, 'h0C2};
        chk_seq("nointlv_data", fifo_log, exp_q);
        chk("nointlv_turnaround", 64'(fifo_cyc[3] - fifo_cyc[2]), 64'(2));

        // ProgFull blocks new grants, Full stalls a running packet.
        clear_logs();
        fifo_prog_full = 1'b1;
        for (int i = 0; i < 4; i++) push_word(0, 0, (i == 3) ? 1 : 0, 'h0D0 + i);
        push_word(2, 0, 1, 'h0E0);
        repeat (5) step();
        chk("pf_no_grant", 64'(grant_log.size()), 64'(0));
        chk("pf_no_write", 64'(fifo_log.size()), 64'(0));
        fifo_prog_full = 1'b0;
        step();
        fifo_prog_full = 1'b1;
        repeat (2) step();
        fifo_full = 1'b1;
        nlog = fifo_log.size();
        repeat (4) step();
        chk("full_no_write", 64'(fifo_log.size() - nlog), 64'(0));
        fifo_full = 1'b0;
        g = 0;
        while (m_busy && g < 20) begin
            step();
            g++;
        end
        chk("pf_burst_done", 64'(g < 20), 64'(1));
        exp_q = '{0};
        chk_seq("pf_grants_mid", grant_log, exp_q);
        fifo_prog_full = 1'b0;
        drain("pf");
        exp_q = '{'h0D0, 'h0D1, 'h0D2, 'h0D3, 'h0E0};
        chk_seq("pf_data", fifo_log, exp_q);

        // Wrap-around: only 3 and 0 compete.
        clear_logs();
        for (int p = 0; p < 3; p++) begin
            push_word(3, 0, 1, 'h130 + p);
            push_word(0, 0, 0, 'h100 + p);
            push_word(0, 0, 1, 'h110 + p);
        end
        drain("wrap");
        exp_q = '{3, 0, 3, 0, 3, 0};
        chk_seq("wrap_grants", grant_log, exp_q);

        // Asynchronous reset in the middle of a packet owned by requester 0.
        clear_logs();
        for (int i = 0; i < 6; i++) push_word(0, 0, (i == 5) ? 1 : 0, 'h0F0 + i);
        repeat (3) step();
        chk("prereset_busy", 64'(busy), 64'(1));
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        for (int i = 0; i < N; i++) wq[i].delete();
        pop_pend = '0;
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        clear_logs();
        push_word(0, 0, 0, 'h051);
        push_word(0, 0, 1, 'h052);
        push_word(2, 0, 1, 'h053);
        drain("postreset");
        exp_q = '{0, 2};
        chk_seq("postreset_grants", grant_log, exp_q);
        exp_q = '{'h051, 'h052, 'h053};
        chk_seq("postreset_data", fifo_log, exp_q);

        // Randomized traffic with random Full / ProgFull back-pressure.
        clear_logs();
        words_pushed = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int r = 0; r < N; r++) begin
                if (wq[r].size() < 2 && $urandom_range(0, 3) == 0) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int i = 0; i < len; i++) begin
                        int gap;
                        gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                        push_word(r, gap, (i == len - 1) ? 1 : 0, int'($urandom_range(0, 511)));
                        words_pushed++;
                    end
                end
            end
            fifo_full      = ($urandom_range(0, 4) == 0);
            fifo_prog_full = ($urandom_range(0, 3) == 0);
            step();
        end
        fifo_full = 1'b0;
        fifo_prog_full = 1'b0;
        drain("rand");
        chk("rand_word_count", 64'(fifo_log.size()), 64'(words_pushed));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin, packet-locked write arbiter that shares one block-RAM FIFO write port (the 9-bit, 8K-deep FIFO) among several producers. A producer holds the grant from its first word until its end-of-packet word, so packets are never interleaved in the FIFO. New packets start only while the FIFO is below its programmable-full threshold. Sits directly in front of the FIFO `Write`/`Din` pins; the FIFO's `Full` and `ProgFull` feed back into it.

## Interface
- `NumReq`, 4: number of requesters, 2..8.
- `Width`, 9: data width; matches FIFO `Din`.
- `IdWidth`, 2: width of `GrantId`; must satisfy 2^IdWidth >= `NumReq`.

- `Clk`, in, 1: single clock; all logic on the rising edge.
- `Reset_n`, in, 1: asynchronous, active-low reset.
- `Req`, in, `NumReq`: per-requester "word available".
- `ReqDin`, in, `NumReq*Width`: requester i data in bits [i*Width +: Width].
- `ReqLast`, in, `NumReq`: word on `ReqDin` slice i is its packet's last word.
- `Ack`, out, `NumReq`: word from requester i is written this cycle.
- `FifoWrite`, out, 1: to FIFO `Write`.
- `FifoDin`, out, `Width`: to FIFO `Din`.
- `FifoFull`, in, 1: from FIFO `Full`.
- `FifoProgFull`, in, 1: from FIFO `ProgFull`.
- `Busy`, out, 1: a packet is in progress (state BURST).
- `GrantId`, out, `IdWidth`: index of the current or last granted requester.

## Operation
- **States:**
  - IDLE: no grant.
  - BURST: one requester owns the port.
- **Round-robin pointer `Last`** (`IdWidth` bits) holds the most recently granted index. The search order is `Last+1`, `Last+2`, … modulo `NumReq`, with wrap from `NumReq-1` to 0.
- **IDLE → BURST:** when `|Req` is 1 and `FifoProgFull` is 0.
  - Grant goes to the first requester in search order with `Req` high.
  - `GrantId` and `Last` are set to that index.
  - No data is transferred in the arbitration cycle.
- **IDLE with `FifoProgFull`=1:** no grant is issued; requests wait.
- **BURST transfer:**
  - `Ack[g] = Req[g] & ~FifoFull`; all other `Ack` bits are 0.
  - `FifoWrite = |Ack`.
  - `FifoDin` = slice g of `ReqDin` while in BURST, and 0 otherwise.
- **BURST hold:** `FifoProgFull` does not interrupt a packet in progress; only `FifoFull` stalls it. If the granted requester drops `Req` mid-packet, the grant is held; the requester owns the port until it delivers its last word.
- **BURST → IDLE:** on the cycle where `Ack[g]` is 1 and `ReqLast[g]` is 1.
- **Single-word packet:** a word with `ReqLast` high as its first word is legal; BURST lasts exactly one transfer.
- **Ignored inputs:** `Req`, `ReqDin` and `ReqLast` of non-granted requesters have no effect.
- **Requester contract:** hold data, last and `Req` stable until acked.

## Timing
- **Reset values** (async on `Reset_n`=0, held while low): state IDLE, `Last`=`NumReq-1` so the first grant goes to requester 0, `GrantId`=0, `Busy`=0, `Ack`=0, `FifoWrite`=0, `FifoDin`=0.
- **Output decode:** `Ack`, `FifoWrite` and `FifoDin` are combinational from state, grant, `Req`, `ReqDin` and `FifoFull`. `Busy` and `GrantId` are registered.
- **Arbitration latency:** `Req` rising in IDLE at cycle n gives `Busy`=1 at n+1; the earliest `Ack` is at n+1.
- **Throughput:** one word per cycle within a packet.
- **Packet turnaround:** one idle cycle between packets. The last word is acked at cycle m; IDLE holds at m+1; the next grant begins at m+2.
- **Full stall:** when `FifoFull`=1 there is no `Ack`. The transfer resumes in the same cycle `FifoFull` falls.
- **Last word under full:** `ReqLast` on a stalled word does not end the packet until the word is acked.
- **Reset mid-packet:** state returns to IDLE immediately. The partial packet already in the FIFO is the system's problem; the FIFO is reset by the same source.

## Test plan
- **Single requester:**
  - Stimulus: after reset, requester 2 presents the 3-word packet 0x101, 0x002, 0x1FF with last on the third word.
  - Required response: grant to 2 (`GrantId`=2); `FifoDin` sequence 0x101, 0x002, 0x1FF on 3 consecutive cycles; `Busy` falls the cycle after the last `Ack`.
- **Round-robin fairness:**
  - Stimulus: all 4 requesters continuously send 2-word packets.
  - Required response: grant order 0,1,2,3,0,…; each packet takes 2 transfer cycles plus 1 arbitration cycle.
- **No interleave:**
  - Stimulus: requester 1 drops `Req` for 5 cycles mid-packet while requester 3 requests.
  - Required response: no `Ack` to 3 until 1's last word is written; the FIFO contents show 1's packet contiguous.
- **Full / ProgFull:**
  - Stimulus: assert `FifoProgFull` in IDLE with requests pending; then assert `FifoFull` for 4 cycles mid-packet.
  - Required response: no grant while `FifoProgFull`=1; with `FifoFull`=1, `FifoWrite`=0 and the word is held; the packet resumes intact.
- **Reset mid-packet:**
  - Stimulus: drop `Reset_n` asynchronously during BURST.
  - Required response: outputs go to reset values without waiting for a clock edge; the next grant goes to requester 0.
- **Wrap-around:**
  - Stimulus: only requesters 3 and 0 request, alternating.
  - Required response: grant order alternates 3 → 0 → 3 with `GrantId` wrapping correctly.
